instr_fetch_unit: RTL and testbench

Instruction fetch unit for the processor: the producing end of the 20-bit instruction bus that the control unit decodes. On a fetch request from the control unit, it updates the program counter using the control unit's PC-select code (increment, jump to the 6-bit target, hold, or restart). It then reads instruction RAM over a req/ack handshake and presents the word in the instruction register with a one-cycle valid strobe. It sits between the instruction RAM and the control unit and owns the PC.

---
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction RAM over a req/ack
// handshake and presents the word in the instruction register with a valid strobe.
module instr_fetch_unit #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 20,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_req,
    input  logic [1:0]         pc_sel,
    input  logic [ADDR_W-1:0]  alpha,
    output logic               iram_req,
    output logic [ADDR_W-1:0]  iram_addr,
    input  logic               iram_ack,
    input  logic [INSTR_W-1:0] iram_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] next_pc;

    always_comb begin
        next_pc = pc;
        case (pc_sel)
            2'b00:   next_pc = pc;
            2'b01:   next_pc = pc + ADDR_W'(1);
            2'b10:   next_pc = alpha;
            default: next_pc = '0;
        endcase
    end

    assign iram_addr = pc;

    // An ack in the timeout cycle wins over the abort, so it is tested first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            iram_req    <= 1'b0;
            busy        <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    instr_valid <= 1'b0;
                    if (fetch_req) begin
                        pc        <= next_pc;
                        wait_cnt  <= '0;
                        fetch_err <= 1'b0;
                        iram_req  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (iram_ack) begin
                        instruction <= iram_rdata;
                        iram_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= DONE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        instruction <= '0;
                        fetch_err   <= 1'b1;
                        iram_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    instr_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    instr_valid <= 1'b0;
                    iram_req    <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, PC wrap sweep,
// randomized fetches against a transaction-level model, and async reset mid-fetch.
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 20;
    localparam int TIMEOUT = 15;

    logic               clk;
    logic               rst_n;
    logic               fetch_req;
    logic [1:0]         pc_sel;
    logic [ADDR_W-1:0]  alpha;
    logic               iram_req;
    logic [ADDR_W-1:0]  iram_addr;
    logic               iram_ack;
    logic [INSTR_W-1:0] iram_rdata;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               fetch_err;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic [1:0]         sel;
        logic [ADDR_W-1:0]  tgt;
        int                 delay;
        logic [INSTR_W-1:0] data;
        logic [ADDR_W-1:0]  exp_pc;
        logic [INSTR_W-1:0] exp_instr;
        logic               exp_err;
        bit                 stray;
    } vec_t;

    vec_t vecs[10];

    instr_fetch_unit #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .pc_sel     (pc_sel),
        .alpha      (alpha),
        .iram_req   (iram_req),
        .iram_addr  (iram_addr),
        .iram_ack   (iram_ack),
        .iram_rdata (iram_rdata),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference PC update rule, in plain modulo arithmetic.
    function automatic int model_pc(input int cur, input int sel, input int tgt);
        case (sel)
            0:       return cur;
            1:       return (cur + 1) % 64;
            2:       return tgt;
            default: return 0;
        endcase
    endfunction

    // Called in an IDLE cycle; returns in the IDLE cycle after the valid pulse,
    // so back-to-back calls issue one request every 3 cycles at best.
    task automatic applyStimulus(input logic [1:0] sel, input logic [ADDR_W-1:0] tgt,
                                 input int delay, input logic [INSTR_W-1:0] data,
                                 input logic [ADDR_W-1:0] exp_pc,
                                 input logic [INSTR_W-1:0] exp_instr,
                                 input logic exp_err, input bit stray);
        int n_req;
        n_req = (delay + 1 <= TIMEOUT) ? delay + 1 : TIMEOUT;
        fetch_req = 1'b1;
        pc_sel    = sel;
        alpha     = tgt;
        iram_ack  = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 1; c <= n_req; c++) begin
            fetch_req  = stray && (c == 2);
            pc_sel     = fetch_req ? 2'b10 : 2'($urandom);
            alpha      = ADDR_W'($urandom);
            iram_ack   = (c == delay + 1);
            iram_rdata = iram_ack ? data : INSTR_W'($urandom);
            @(negedge clk);
            checkOutput("req_high", 32'(iram_req), 32'd1);
            checkOutput("req_addr", 32'(iram_addr), 32'(exp_pc));
            checkOutput("req_pc", 32'(pc), 32'(exp_pc));
            checkOutput("req_busy", 32'(busy), 32'd1);
            checkOutput("req_valid", 32'(instr_valid), 32'd0);
            checkOutput("req_err", 32'(fetch_err), 32'd0);
            @(posedge clk);
            #1;
        end
        fetch_req  = 1'b0;
        iram_ack   = 1'($urandom);
        iram_rdata = INSTR_W'($urandom);
        @(negedge clk);
        checkOutput("done_valid", 32'(instr_valid), 32'd1);
        checkOutput("done_req", 32'(iram_req), 32'd0);
        checkOutput("done_instr", 32'(instruction), 32'(exp_instr));
        checkOutput("done_err", 32'(fetch_err), 32'(exp_err));
        checkOutput("done_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        iram_ack   = 1'($urandom);
        iram_rdata = INSTR_W'($urandom);
        @(negedge clk);
        checkOutput("idle_valid", 32'(instr_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_instr", 32'(instruction), 32'(exp_instr));
        checkOutput("idle_pc", 32'(pc), 32'(exp_pc));
        checkOutput("idle_err", 32'(fetch_err), 32'(exp_err));
        iram_ack = 1'b0;
    endtask

    initial begin
        int cur_pc;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        pc_sel     = 2'b00;
        alpha      = '0;
        iram_ack   = 1'b0;
        iram_rdata = '0;

        vecs[0] = '{2'b00, 6'h00, 0,  20'h4A123, 6'h00, 20'h4A123, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 6'h05, 0,  20'h11111, 6'h05, 20'h11111, 1'b0, 1'b0};
        vecs[2] = '{2'b10, 6'h2C, 0,  20'h22222, 6'h2C, 20'h22222, 1'b0, 1'b0};
        vecs[3] = '{2'b01, 6'h00, 0,  20'h33333, 6'h2D, 20'h33333, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 6'h3F, 0,  20'h44444, 6'h00, 20'h44444, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 6'h00, 4,  20'h5B0C1, 6'h01, 20'h5B0C1, 1'b0, 1'b1};
        vecs[6] = '{2'b00, 6'h00, 20, 20'hFFFFF, 6'h01, 20'h00000, 1'b1, 1'b1};
        vecs[7] = '{2'b01, 6'h00, 14, 20'h7FEED, 6'h02, 20'h7FEED, 1'b0, 1'b0};
        vecs[8] = '{2'b00, 6'h00, 15, 20'hABCDE, 6'h02, 20'h00000, 1'b1, 1'b0};
        vecs[9] = '{2'b01, 6'h00, 0,  20'hC0DE1, 6'h03, 20'hC0DE1, 1'b0, 1'b0};

        #12;
        checkOutput("rst_req", 32'(iram_req), 32'd0);
        checkOutput("rst_addr", 32'(iram_addr), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_instr", 32'(instruction), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(fetch_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++)
            applyStimulus(vecs[i].sel, vecs[i].tgt, vecs[i].delay, vecs[i].data,
                          vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_err, vecs[i].stray);

        $display("[TB] increment and wrap sweep");
        applyStimulus(2'b11, 6'h15, 0, 20'h00001, 6'h00, 20'h00001, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            logic [INSTR_W-1:0] d;
            d = INSTR_W'($urandom);
            applyStimulus(2'b01, 6'h00, 0, d, ADDR_W'((i + 1) % 64), d, 1'b0, 1'b0);
        end

        $display("[TB] randomized fetches");
        cur_pc = 0;
        for (int i = 0; i < 40; i++) begin
            int sel, tgt, dly;
            logic [INSTR_W-1:0] d;
            bit ok;
            sel = int'($urandom_range(0, 3));
            tgt = int'($urandom_range(0, 63));
            dly = int'($urandom_range(0, 18));
            d   = INSTR_W'($urandom);
            ok  = (dly + 1 <= TIMEOUT);
            cur_pc = model_pc(cur_pc, sel, tgt);
            applyStimulus(2'(sel), ADDR_W'(tgt), dly, d, ADDR_W'(cur_pc),
                          ok ? d : '0, !ok, 1'($urandom));
        end

        $display("[TB] async reset mid-fetch");
        fetch_req = 1'b1;
        pc_sel    = 2'b10;
        alpha     = 6'h2A;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        @(negedge clk);
        checkOutput("ar_req_before", 32'(iram_req), 32'd1);
        checkOutput("ar_pc_before", 32'(pc), 32'h2A);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_req_drop", 32'(iram_req), 32'd0);
        checkOutput("ar_busy_drop", 32'(busy), 32'd0);
        checkOutput("ar_pc_drop", 32'(pc), 32'd0);
        iram_ack   = 1'b1;
        iram_rdata = 20'hABCDE;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("ar_no_valid", 32'(instr_valid), 32'd0);
            checkOutput("ar_instr", 32'(instruction), 32'd0);
            checkOutput("ar_busy", 32'(busy), 32'd0);
        end
        iram_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
